truth_table_checker: RTL and testbench

- Response side of the gate-level truth-table benches: consumes (input vector, DUT output) pairs and checks each output against a programmed expected truth table.
- Tracks which input combinations have been seen, counts mismatches, and declares done/pass once every combination has been covered.
- Sits between a gate-level DUT (e.g. a 3- or 4-input combinational block) and a stimulus sweeper. Allows self-checking in simulation or on-chip without $monitor inspection.

---
 rtl/tt_check_pkg.sv | 17 +
 rtl/tt_idle_timer.sv | 28 ++
 rtl/truth_table_checker.sv | 121 ++++++++++++
 tb/tb_truth_table_checker.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_check_pkg.sv
// Shared types and helpers for the truth-table checker slice.
package tt_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_IN_DEFAULT = 4;

  // Increments value but never past limit; callers cast to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
    return (value >= limit) ? limit : value + 32'd1;
  endfunction

endpackage

// File: rtl/tt_idle_timer.sv
// Loadable idle counter: flags expiry on the enabled cycle that reaches TERMINAL.
module tt_idle_timer
  import tt_check_pkg::*;
#(
  parameter int TERMINAL = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TERMINAL + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (enable)
      count <= W'(sat_inc(32'(count), 32'(TERMINAL)));
  end

  // Fires one cycle early so the caller's state change lands on the TERMINAL-th idle edge.
  assign expire = enable && (32'(count) == 32'(TERMINAL - 1));

endmodule

// File: rtl/truth_table_checker.sv
// Checks (in_vec, in_y) samples against a latched truth table and tracks row coverage.
// Optional idle timeout enabled by defining TT_CHECK_TIMEOUT_EN.
module truth_table_checker
  import tt_check_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int DEPTH = 2 ** N_IN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DEPTH-1:0] expected,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  input  logic             in_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_count,
  output logic             first_err_valid,
  output logic [N_IN-1:0]  first_err_vec,
`ifdef TT_CHECK_TIMEOUT_EN
  output logic             timeout,
`endif
  output logic [DEPTH-1:0] coverage
);

  localparam int ERR_W = N_IN + 1;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t           state, state_next;
  logic [DEPTH-1:0] exp_q;
  logic [DEPTH-1:0] cov_next;
  logic             accept, start_run, mismatch, last_row, expire, timed_out;

  assign accept    = in_valid && in_ready;
  assign start_run = start && (state != RUN);
  assign mismatch  = in_y != exp_q[in_vec];
  assign cov_next  = coverage | (DEPTH'(1) << in_vec);
  assign last_row  = accept && (&cov_next);

`ifdef TT_CHECK_TIMEOUT_EN
  tt_idle_timer #(
    .TERMINAL(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_run || accept),
    .enable ((state == RUN) && !accept),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset || start_run)
      timed_out <= 1'b0;
    else if ((state == RUN) && expire)
      timed_out <= 1'b1;
  end

  assign timeout = timed_out;
`else
  assign expire    = 1'b0;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_row || expire) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == RUN);
    busy     = (state == RUN);
    done     = (state == DONE);
    pass     = done && (err_count == '0) && !timed_out;
  end

  // Only the first mismatch of a run is recorded; err_count keeps counting up to DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q           <= '0;
      coverage        <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else if (start_run) begin
      exp_q           <= expected;
      coverage        <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else if (accept) begin
      coverage <= cov_next;
      if (mismatch) begin
        err_count <= ERR_W'(sat_inc(32'(err_count), 32'(DEPTH)));
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_vec   <= in_vec;
        end
      end
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench for truth_table_checker: directed vector tables plus randomized runs
// against a row-coverage model. Timeout scenario runs when TT_CHECK_TIMEOUT_EN is defined.
module tb_truth_table_checker;

  localparam int N = 4;
  localparam int D = 16;

  typedef struct {
    logic [N-1:0] vec;
    logic         y;
    int           gap;
    int           exp_err;
    logic         exp_done;
  } vec_rec_t;

  logic         clk = 1'b0;
  logic         reset, start, in_valid, in_y;
  logic [D-1:0] expected;
  logic [N-1:0] in_vec;
  logic         in_ready, busy, done, pass, first_err_valid;
  logic [N:0]   err_count;
  logic [N-1:0] first_err_vec;
  logic [D-1:0] coverage;
`ifdef TT_CHECK_TIMEOUT_EN
  logic         timeout;
`endif

  int tests = 0;
  int fails = 0;
  vec_rec_t tbl[$];

  truth_table_checker #(
    .N_IN(N),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .expected        (expected),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_vec          (in_vec),
    .in_y            (in_y),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_vec   (first_err_vec),
`ifdef TT_CHECK_TIMEOUT_EN
    .timeout         (timeout),
`endif
    .coverage        (coverage)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] want);
    tests++;
    if (actual !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic y, input int gap);
    in_valid = 1'b0;
    repeat (gap) tick();
    in_vec   = v;
    in_y     = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_vec   = N'($urandom);
    in_y     = 1'($urandom);
  endtask

  task automatic startRun(input logic [D-1:0] e);
    expected = e;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    expected = D'($urandom);
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, " in_ready"}, 32'(in_ready), 0);
    checkOutput({tag, " busy"}, 32'(busy), 0);
    checkOutput({tag, " done"}, 32'(done), 0);
    checkOutput({tag, " pass"}, 32'(pass), 0);
    checkOutput({tag, " err_count"}, 32'(err_count), 0);
    checkOutput({tag, " first_err_valid"}, 32'(first_err_valid), 0);
    checkOutput({tag, " first_err_vec"}, 32'(first_err_vec), 0);
    checkOutput({tag, " coverage"}, 32'(coverage), 0);
  endtask

  function automatic vec_rec_t rec(input int v, input logic y, input int gap, input int err, input logic dn);
    vec_rec_t r;
    r.vec      = N'(v);
    r.y        = y;
    r.gap      = gap;
    r.exp_err  = err;
    r.exp_done = dn;
    return r;
  endfunction

  task automatic runTable(input string tag, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      applyStimulus(tbl[i].vec, tbl[i].y, tbl[i].gap);
      checkOutput($sformatf("%s[%0d] err_count", tag, i), 32'(err_count), 32'(tbl[i].exp_err));
      checkOutput($sformatf("%s[%0d] done", tag, i), 32'(done), 32'(tbl[i].exp_done));
    end
  endtask

  task automatic loadAnd4();
    tbl.delete();
    for (int i = 0; i < D; i++) tbl.push_back(rec(i, i == 15, 0, 0, i == 15));
  endtask

  task automatic randomRuns(input int runs);
    logic [D-1:0] exp_bits;
    logic [D-1:0] seen;
    int           errs, first, steps;
    logic [N-1:0] v;
    logic         flip;
    for (int r = 0; r < runs; r++) begin
      exp_bits = D'($urandom);
      seen     = '0;
      errs     = 0;
      first    = -1;
      steps    = 0;
      startRun(exp_bits);
      while (seen != {D{1'b1}} && steps < 2000) begin
        v    = N'($urandom_range(0, D - 1));
        flip = (r % 4 != 0) && ($urandom_range(0, 3) == 0);
        applyStimulus(v, exp_bits[v] ^ flip, $urandom_range(0, 2));
        if (flip) begin
          if (errs < D) errs++;
          if (first < 0) first = int'(v);
        end
        seen[v] = 1'b1;
        steps++;
        checkOutput($sformatf("rand%0d step%0d err_count", r, steps), 32'(err_count), 32'(errs));
        checkOutput($sformatf("rand%0d step%0d done", r, steps), 32'(done), 32'(seen == {D{1'b1}}));
      end
      checkOutput($sformatf("rand%0d coverage", r), 32'(coverage), 32'(seen));
      checkOutput($sformatf("rand%0d busy", r), 32'(busy), 0);
      checkOutput($sformatf("rand%0d pass", r), 32'(pass), 32'(errs == 0));
      checkOutput($sformatf("rand%0d first_err_valid", r), 32'(first_err_valid), 32'(first >= 0));
      checkOutput($sformatf("rand%0d first_err_vec", r), 32'(first_err_vec), 32'(first >= 0 ? first : 0));
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_vec   = '0;
    in_y     = 1'b0;
    expected = '0;
    tick();
    tick();
    reset = 1'b0;
    checkCleared("reset");

    // Samples offered while idle must be dropped.
    in_vec   = 4'd5;
    in_y     = 1'b1;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    checkCleared("idle gating");

    // Clean AND4 sweep.
    loadAnd4();
    startRun(16'h8000);
    checkOutput("and4 busy after start", 32'(busy), 1);
    checkOutput("and4 in_ready after start", 32'(in_ready), 1);
    runTable("and4", 0, 15);
    checkOutput("and4 pass", 32'(pass), 1);
    checkOutput("and4 busy", 32'(busy), 0);
    checkOutput("and4 coverage", 32'(coverage), 32'hFFFF);
    checkOutput("and4 first_err_valid", 32'(first_err_valid), 0);

    // Samples offered while done are dropped too.
    applyStimulus(4'd3, 1'b1, 0);
    checkOutput("done gating err_count", 32'(err_count), 0);
    checkOutput("done gating pass", 32'(pass), 1);

    // Majority of the low three inputs, y flipped on rows 2 and 5.
    begin
      logic [D-1:0] maj;
      maj = 16'hE8E8;
      tbl.delete();
      for (int i = 0; i < D; i++)
        tbl.push_back(rec(i, maj[i] ^ (i == 2 || i == 5), 0, (i < 2) ? 0 : (i < 5) ? 1 : 2, i == 15));
      startRun(maj);
      runTable("inject", 0, 15);
      checkOutput("inject first_err_vec", 32'(first_err_vec), 2);
      checkOutput("inject first_err_valid", 32'(first_err_valid), 1);
      checkOutput("inject pass", 32'(pass), 0);
    end

    // Duplicates with backpressure gaps; parity table, mismatch on the second row 1.
    begin
      logic [D-1:0] par;
      int           seq[$];
      par = 16'h6996;
      seq = '{0, 0, 1, 1};
      for (int i = 2; i < D; i++) seq.push_back(i);
      tbl.delete();
      for (int i = 0; i < seq.size(); i++)
        tbl.push_back(rec(seq[i], par[seq[i]] ^ (i == 3), i % 3, (i < 3) ? 0 : 1, i == seq.size() - 1));
      startRun(par);
      runTable("dup", 0, 6);
      checkOutput("dup coverage mid", 32'(coverage), 32'h001F);
      expected = 16'hFFFF;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      checkOutput("mid-run start busy", 32'(busy), 1);
      checkOutput("mid-run start coverage", 32'(coverage), 32'h001F);
      checkOutput("mid-run start err_count", 32'(err_count), 1);
      runTable("dup", 7, seq.size() - 2);
      checkOutput("dup coverage before last", 32'(coverage), 32'h7FFF);
      runTable("dup", seq.size() - 1, seq.size() - 1);
      checkOutput("dup first_err_vec", 32'(first_err_vec), 1);
      checkOutput("dup pass", 32'(pass), 0);
    end

    // Reset in the middle of a run discards everything.
    startRun(16'h8000);
    for (int i = 0; i < 7; i++) applyStimulus(N'(i), i == 3, 0);
    checkOutput("midreset err before", 32'(err_count), 1);
    pulseReset();
    checkCleared("midreset");
    loadAnd4();
    startRun(16'h8000);
    runTable("after reset", 0, 15);
    checkOutput("after reset pass", 32'(pass), 1);

    // err_count saturates at DEPTH.
    startRun(16'h0000);
    for (int i = 0; i < 20; i++) applyStimulus(4'd0, 1'b1, 0);
    checkOutput("sat err_count", 32'(err_count), D);
    checkOutput("sat busy", 32'(busy), 1);
    checkOutput("sat coverage", 32'(coverage), 32'h0001);
    for (int i = 1; i < D; i++) applyStimulus(N'(i), 1'b1, 0);
    checkOutput("sat err_count final", 32'(err_count), D);
    checkOutput("sat done", 32'(done), 1);
    checkOutput("sat pass", 32'(pass), 0);

    randomRuns(20);

`ifdef TT_CHECK_TIMEOUT_EN
    startRun(16'h0000);
    for (int i = 0; i < 3; i++) applyStimulus(N'(i), 1'b0, 0);
    repeat (7) tick();
    checkOutput("timeout early done", 32'(done), 0);
    checkOutput("timeout early flag", 32'(timeout), 0);
    tick();
    checkOutput("timeout done", 32'(done), 1);
    checkOutput("timeout flag", 32'(timeout), 1);
    checkOutput("timeout pass", 32'(pass), 0);
    checkOutput("timeout coverage", 32'(coverage), 32'h0007);
    startRun(16'h0000);
    checkOutput("timeout cleared by start", 32'(timeout), 0);
    checkOutput("timeout restart busy", 32'(busy), 1);
    pulseReset();
    checkOutput("timeout after reset", 32'(timeout), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
